paddle_array: RTL and testbench

Parametrised successor to the single-paddle block. Drives `NUM_PADDLES` independent paddles, each on its own fixed lane, moving along one selectable axis, with velocity ramping and exact edge clamping. Sits between the button inputs and the HDMI pixel mux. Exports per-paddle positions for the ball/collision logic and a merged RGB pixel for the current raster position.

---
 rtl/pong_pkg.sv | 36 +++
 rtl/paddle_channel.sv | 184 ++++++++++++++++++
 rtl/paddle_array.sv | 69 ++++++
 tb/tb_paddle_array.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// Shared types and helpers for the paddle array: frame direction, per-paddle
// movement states, coordinate width and a signed clamp onto an unsigned coordinate.
package pong_pkg;

    localparam int COORD_W = 12;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        NEG  = 2'd1,
        POS  = 2'd2
    } dir_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MOVE_NEG = 2'd1,
        MOVE_POS = 2'd2
    } pstate_t;

    // Saturate a one-bit-wider signed value into [lo, hi] and return it as a coordinate.
    function automatic logic [COORD_W-1:0] clamp(
        input logic signed [COORD_W:0] v,
        input logic signed [COORD_W:0] lo,
        input logic signed [COORD_W:0] hi
    );
        logic signed [COORD_W:0] r;
        if (v < lo) begin
            r = lo;
        end else if (v > hi) begin
            r = hi;
        end else begin
            r = v;
        end
        return COORD_W'(r);
    endfunction

endpackage

// File: rtl/paddle_channel.sv
// One paddle: button synchronisers, sticky per-frame requests, movement FSM with
// velocity ramp, clamped position and the raster hit test for its fixed lane.
module paddle_channel
    import pong_pkg::*;
#(
    parameter int HRES       = 1280,
    parameter int VRES       = 720,
    parameter int AXIS       = 0,
    parameter int PADDLE_LEN = 200,
    parameter int PADDLE_THK = 20,
    parameter int LANE       = 0,
    parameter int VEL_MIN    = 4,
    parameter int VEL_STEP   = 4,
    parameter int VEL_MAX    = 32
) (
    input  logic                      pixel_clk,
    input  logic                      rst_n,
    input  logic                      fsync,
    input  logic signed [COORD_W-1:0] hpos,
    input  logic signed [COORD_W-1:0] vpos,
    input  logic                      btn_pos,
    input  logic                      btn_neg,
    output logic [COORD_W-1:0]        pos,
    output logic                      active
);

    localparam int AXIS_LEN = (AXIS == 0) ? HRES : VRES;
    localparam int POS_MAX  = AXIS_LEN - PADDLE_LEN;
    localparam int POS_RST  = POS_MAX / 2;

    localparam logic [COORD_W-1:0]        POS_RST_C  = COORD_W'(POS_RST);
    localparam logic signed [COORD_W:0]   POS_MAX_S  = (COORD_W+1)'(POS_MAX);
    localparam logic signed [COORD_W:0]   ZERO_S     = '0;
    localparam logic signed [COORD_W:0]   LEN_S      = (COORD_W+1)'(PADDLE_LEN);
    localparam logic signed [COORD_W:0]   LANE_LO_S  = (COORD_W+1)'(LANE);
    localparam logic signed [COORD_W:0]   LANE_HI_S  = (COORD_W+1)'(LANE + PADDLE_THK);
    localparam logic [COORD_W-1:0]        VEL_MIN_C  = COORD_W'(VEL_MIN);
    localparam logic [COORD_W-1:0]        VEL_STEP_C = COORD_W'(VEL_STEP);
    localparam logic [COORD_W-1:0]        VEL_MAX_C  = COORD_W'(VEL_MAX);

    logic [1:0]         pos_sync_q;
    logic [1:0]         neg_sync_q;
    logic               req_pos_q, req_pos_d;
    logic               req_neg_q, req_neg_d;
    pstate_t            state_q, state_d;
    logic [COORD_W-1:0] vel_q, vel_d;
    logic [COORD_W-1:0] pos_q, pos_d;

    dir_t                    dir_s;
    logic [COORD_W-1:0]      vel_inc_s;
    logic [COORD_W-1:0]      vel_sat_s;
    logic signed [COORD_W:0] step_s;
    logic signed [COORD_W:0] cur_s;

    // Two-flop synchronisers for the asynchronous buttons.
    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            pos_sync_q <= 2'b00;
            neg_sync_q <= 2'b00;
        end else begin
            pos_sync_q <= {pos_sync_q[0], btn_pos};
            neg_sync_q <= {neg_sync_q[0], btn_neg};
        end
    end

    // Sticky requests: set by any synchronised sample outside the fsync cycle, cleared by fsync.
    always_comb begin
        req_pos_d = req_pos_q;
        req_neg_d = req_neg_q;
        if (fsync) begin
            req_pos_d = 1'b0;
            req_neg_d = 1'b0;
        end else begin
            req_pos_d = req_pos_q | pos_sync_q[1];
            req_neg_d = req_neg_q | neg_sync_q[1];
        end
    end

    // Frame direction from the flags as they stand when fsync is sampled.
    always_comb begin
        dir_s = NONE;
        if (req_pos_q && !req_neg_q) begin
            dir_s = POS;
        end else if (req_neg_q && !req_pos_q) begin
            dir_s = NEG;
        end else begin
            dir_s = NONE;
        end
    end

    // Velocity ramp candidate for staying in the same move state.
    always_comb begin
        vel_inc_s = vel_q + VEL_STEP_C;
        if (vel_inc_s > VEL_MAX_C) begin
            vel_sat_s = VEL_MAX_C;
        end else begin
            vel_sat_s = vel_inc_s;
        end
    end

    // Movement FSM, velocity and clamped position, all advanced only on fsync.
    always_comb begin
        state_d = state_q;
        vel_d   = vel_q;
        pos_d   = pos_q;
        step_s  = '0;
        cur_s   = $signed({1'b0, pos_q});
        if (fsync) begin
            case (dir_s)
                POS: begin
                    state_d = MOVE_POS;
                    if (state_q == MOVE_POS) begin
                        vel_d = vel_sat_s;
                    end else begin
                        vel_d = VEL_MIN_C;
                    end
                end
                NEG: begin
                    state_d = MOVE_NEG;
                    if (state_q == MOVE_NEG) begin
                        vel_d = vel_sat_s;
                    end else begin
                        vel_d = VEL_MIN_C;
                    end
                end
                default: begin
                    state_d = IDLE;
                    vel_d   = '0;
                end
            endcase
            // Widened by one signed bit so overshoot past either bound clamps instead of wrapping.
            step_s = $signed({1'b0, vel_d});
            case (dir_s)
                POS:     pos_d = clamp(cur_s + step_s, ZERO_S, POS_MAX_S);
                NEG:     pos_d = clamp(cur_s - step_s, ZERO_S, POS_MAX_S);
                default: pos_d = pos_q;
            endcase
        end else begin
            state_d = state_q;
            vel_d   = vel_q;
            pos_d   = pos_q;
        end
    end

    // Request flags, FSM state, velocity and position registers.
    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            req_pos_q <= 1'b0;
            req_neg_q <= 1'b0;
            state_q   <= IDLE;
            vel_q     <= '0;
            pos_q     <= POS_RST_C;
        end else begin
            req_pos_q <= req_pos_d;
            req_neg_q <= req_neg_d;
            state_q   <= state_d;
            vel_q     <= vel_d;
            pos_q     <= pos_d;
        end
    end

    logic signed [COORD_W:0] along_s;
    logic signed [COORD_W:0] cross_s;
    logic signed [COORD_W:0] lo_s;
    logic signed [COORD_W:0] hi_s;

    // Half-open hit test so exactly PADDLE_LEN x PADDLE_THK pixels light.
    always_comb begin
        if (AXIS == 0) begin
            along_s = {hpos[COORD_W-1], hpos};
            cross_s = {vpos[COORD_W-1], vpos};
        end else begin
            along_s = {vpos[COORD_W-1], vpos};
            cross_s = {hpos[COORD_W-1], hpos};
        end
        lo_s   = $signed({1'b0, pos_q});
        hi_s   = lo_s + LEN_S;
        active = (along_s >= lo_s) && (along_s < hi_s) &&
                 (cross_s >= LANE_LO_S) && (cross_s < LANE_HI_S);
    end

    assign pos = pos_q;

endmodule

// File: rtl/paddle_array.sv
// Array of independent paddles on fixed lanes; packs their positions for the
// ball logic and merges their hits into one RGB pixel for the HDMI mux.
module paddle_array
    import pong_pkg::*;
#(
    parameter int          HRES        = 1280,
    parameter int          VRES        = 720,
    parameter int          NUM_PADDLES = 2,
    parameter int          AXIS        = 0,
    parameter int          PADDLE_LEN  = 200,
    parameter int          PADDLE_THK  = 20,
    parameter int          LANE0       = 0,
    parameter int          LANE_STEP   = 700,
    parameter int          VEL_MIN     = 4,
    parameter int          VEL_STEP    = 4,
    parameter int          VEL_MAX     = 32,
    parameter logic [23:0] COLOR       = 24'hEFE62E
) (
    input  logic                              pixel_clk,
    input  logic                              rst_n,
    input  logic                              fsync,
    input  logic signed [COORD_W-1:0]         hpos,
    input  logic signed [COORD_W-1:0]         vpos,
    input  logic [NUM_PADDLES-1:0]            btn_pos,
    input  logic [NUM_PADDLES-1:0]            btn_neg,
    output logic [COORD_W*NUM_PADDLES-1:0]    pos,
    output logic [NUM_PADDLES-1:0]            active,
    output logic [7:0]                        pixel_r,
    output logic [7:0]                        pixel_g,
    output logic [7:0]                        pixel_b
);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_PADDLES; gi++) begin : g_paddle
            paddle_channel #(
                .HRES       (HRES),
                .VRES       (VRES),
                .AXIS       (AXIS),
                .PADDLE_LEN (PADDLE_LEN),
                .PADDLE_THK (PADDLE_THK),
                .LANE       (LANE0 + gi * LANE_STEP),
                .VEL_MIN    (VEL_MIN),
                .VEL_STEP   (VEL_STEP),
                .VEL_MAX    (VEL_MAX)
            ) u_channel (
                .pixel_clk (pixel_clk),
                .rst_n     (rst_n),
                .fsync     (fsync),
                .hpos      (hpos),
                .vpos      (vpos),
                .btn_pos   (btn_pos[gi]),
                .btn_neg   (btn_neg[gi]),
                .pos       (pos[gi*COORD_W +: COORD_W]),
                .active    (active[gi])
            );
        end
    endgenerate

    // Overlapping paddles simply OR together into one colour.
    always_comb begin
        if (|active) begin
            {pixel_r, pixel_g, pixel_b} = COLOR;
        end else begin
            {pixel_r, pixel_g, pixel_b} = 24'h000000;
        end
    end

endmodule

// File: tb/tb_paddle_array.sv
// Directed bench for paddle_array with default parameters (two horizontal paddles).
module tb_paddle_array;

    logic               pixel_clk;
    logic               rst_n;
    logic               fsync;
    logic signed [11:0] hpos;
    logic signed [11:0] vpos;
    logic [1:0]         btn_pos;
    logic [1:0]         btn_neg;
    logic [23:0]        pos;
    logic [1:0]         active;
    logic [7:0]         pixel_r;
    logic [7:0]         pixel_g;
    logic [7:0]         pixel_b;

    int checks;
    int failures;

    paddle_array dut (
        .pixel_clk (pixel_clk),
        .rst_n     (rst_n),
        .fsync     (fsync),
        .hpos      (hpos),
        .vpos      (vpos),
        .btn_pos   (btn_pos),
        .btn_neg   (btn_neg),
        .pos       (pos),
        .active    (active),
        .pixel_r   (pixel_r),
        .pixel_g   (pixel_g),
        .pixel_b   (pixel_b)
    );

    initial pixel_clk = 1'b0;
    always #5 pixel_clk = ~pixel_clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d (0x%0h) exp=%0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // One self-contained frame: press, release, let the synchroniser drain, then fsync.
    task automatic run_frame(input logic [1:0] bp, input logic [1:0] bn);
        btn_pos = bp;
        btn_neg = bn;
        repeat (4) @(posedge pixel_clk);
        #1;
        btn_pos = 2'b00;
        btn_neg = 2'b00;
        repeat (4) @(posedge pixel_clk);
        #1;
        fsync = 1'b1;
        @(posedge pixel_clk);
        #1;
        fsync = 1'b0;
    endtask

    task automatic set_raster(input int x, input int y);
        hpos = 12'(x);
        vpos = 12'(y);
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        fsync    = 1'b0;
        btn_pos  = 2'b00;
        btn_neg  = 2'b00;
        hpos     = 12'sd0;
        vpos     = 12'sd0;
        repeat (3) @(posedge pixel_clk);
        #1;
        check_eq("rst_pos_held", 32'(pos), {8'd0, 12'd540, 12'd540});
        rst_n = 1'b1;
        @(posedge pixel_clk);
        #1;
        check_eq("rst_pos0", 32'(pos[11:0]), 32'd540);
        check_eq("rst_pos1", 32'(pos[23:12]), 32'd540);

        // Hit-test edges around the reset positions.
        set_raster(540, 0);
        check_eq("hit_left_edge", 32'(active), 32'd1);
        check_eq("pix_on", 32'({pixel_r, pixel_g, pixel_b}), 32'h00EFE62E);
        set_raster(539, 0);
        check_eq("hit_left_out", 32'(active), 32'd0);
        check_eq("pix_off", 32'({pixel_r, pixel_g, pixel_b}), 32'd0);
        set_raster(739, 19);
        check_eq("hit_corner_in", 32'(active), 32'd1);
        set_raster(740, 19);
        check_eq("hit_right_out", 32'(active), 32'd0);
        set_raster(739, 20);
        check_eq("hit_thk_out", 32'(active), 32'd0);
        set_raster(540, 700);
        check_eq("hit_lane1_top", 32'(active), 32'd2);
        set_raster(540, 719);
        check_eq("hit_lane1_bot", 32'(active), 32'd2);
        set_raster(540, 720);
        check_eq("hit_lane1_out", 32'(active), 32'd0);
        set_raster(-1, 5);
        check_eq("hit_neg_x", 32'(active), 32'd0);

        // Velocity ramp on paddle 0; paddle 1 must not move.
        run_frame(2'b01, 2'b00);
        check_eq("ramp_f1", 32'(pos[11:0]), 32'd544);
        check_eq("ramp_f1_p1", 32'(pos[23:12]), 32'd540);
        run_frame(2'b01, 2'b00);
        check_eq("ramp_f2", 32'(pos[11:0]), 32'd552);
        run_frame(2'b01, 2'b00);
        check_eq("ramp_f3", 32'(pos[11:0]), 32'd564);
        run_frame(2'b01, 2'b00);
        check_eq("ramp_f4", 32'(pos[11:0]), 32'd580);
        check_eq("ramp_f4_p1", 32'(pos[23:12]), 32'd540);
        for (int f = 5; f <= 8; f++) run_frame(2'b01, 2'b00);
        check_eq("ramp_f8", 32'(pos[11:0]), 32'd684);
        for (int f = 9; f <= 20; f++) run_frame(2'b01, 2'b00);
        check_eq("ramp_f20", 32'(pos[11:0]), 32'd1068);
        run_frame(2'b01, 2'b00);
        check_eq("clamp_hi", 32'(pos[11:0]), 32'd1080);
        run_frame(2'b01, 2'b00);
        check_eq("clamp_hi_pinned", 32'(pos[11:0]), 32'd1080);
        run_frame(2'b00, 2'b00);
        check_eq("idle_frame", 32'(pos[11:0]), 32'd1080);
        run_frame(2'b00, 2'b01);
        check_eq("neg_restart", 32'(pos[11:0]), 32'd1076);

        // Both buttons cancel and force IDLE, so the next press restarts at VEL_MIN.
        run_frame(2'b10, 2'b00);
        check_eq("p1_pos", 32'(pos[23:12]), 32'd544);
        run_frame(2'b10, 2'b10);
        check_eq("p1_both", 32'(pos[23:12]), 32'd544);
        run_frame(2'b10, 2'b00);
        check_eq("p1_after_both", 32'(pos[23:12]), 32'd548);
        check_eq("p0_untouched", 32'(pos[11:0]), 32'd1076);

        // Press arriving on the fsync cycle itself belongs to the next frame.
        btn_pos = 2'b01;
        fsync   = 1'b1;
        @(posedge pixel_clk);
        #1;
        fsync = 1'b0;
        check_eq("fsync_press_now", 32'(pos[11:0]), 32'd1076);
        repeat (3) @(posedge pixel_clk);
        #1;
        btn_pos = 2'b00;
        repeat (4) @(posedge pixel_clk);
        #1;
        fsync = 1'b1;
        @(posedge pixel_clk);
        #1;
        fsync = 1'b0;
        check_eq("fsync_press_next", 32'(pos[11:0]), 32'd1080);

        // Back-to-back fsyncs: the second sees cleared flags.
        btn_neg = 2'b01;
        repeat (4) @(posedge pixel_clk);
        #1;
        btn_neg = 2'b00;
        repeat (4) @(posedge pixel_clk);
        #1;
        fsync = 1'b1;
        @(posedge pixel_clk);
        #1;
        check_eq("dbl_fsync_1", 32'(pos[11:0]), 32'd1076);
        @(posedge pixel_clk);
        #1;
        fsync = 1'b0;
        check_eq("dbl_fsync_2", 32'(pos[11:0]), 32'd1076);

        // Asynchronous reset mid-movement with a request pending.
        run_frame(2'b00, 2'b10);
        run_frame(2'b00, 2'b10);
        run_frame(2'b00, 2'b10);
        check_eq("p1_moving", 32'(pos[23:12]), 32'd524);
        btn_neg = 2'b10;
        repeat (5) @(posedge pixel_clk);
        #1;
        rst_n = 1'b0;
        #2;
        check_eq("async_rst", 32'(pos), {8'd0, 12'd540, 12'd540});
        btn_neg = 2'b00;
        repeat (3) @(posedge pixel_clk);
        #1;
        rst_n = 1'b1;
        run_frame(2'b00, 2'b00);
        check_eq("post_rst_frame", 32'(pos), {8'd0, 12'd540, 12'd540});

        // Long hold on paddle 1 toward zero: saturating velocity and lower clamp.
        for (int f = 1; f <= 12; f++) run_frame(2'b00, 2'b10);
        check_eq("neg_f12", 32'(pos[23:12]), 32'd268);
        for (int f = 13; f <= 20; f++) run_frame(2'b00, 2'b10);
        check_eq("neg_f20", 32'(pos[23:12]), 32'd12);
        run_frame(2'b00, 2'b10);
        check_eq("clamp_lo", 32'(pos[23:12]), 32'd0);
        run_frame(2'b00, 2'b10);
        check_eq("clamp_lo_pinned", 32'(pos[23:12]), 32'd0);
        check_eq("neg_p0_still", 32'(pos[11:0]), 32'd540);

        // Hit test on the pinned paddle 1.
        set_raster(0, 700);
        check_eq("hit_p1_origin", 32'(active), 32'd2);
        set_raster(199, 719);
        check_eq("hit_p1_far", 32'(active), 32'd2);
        set_raster(200, 710);
        check_eq("hit_p1_out", 32'(active), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
